// File: rtl/sim_run_controller.sv
// sim_run_controller
// Run-control and supervision block that sits between the bench clock/reset
// and the core. It holds the core in reset for RESET_CYCLES clocks, then lets
// it run. While running it counts cycles and retired instructions. It ends
// the run when any of these happens:
//   - a halt instruction retires,
//   - the PC stays stuck (hang),
//   - the cycle budget runs out.
// It then freezes the core and reports why. A restart pulse in DONE begins a
// fresh run.
//
// Ports:
//   clk          system clock, rising edge
//   reset        asynchronous, active-low (0 = in reset)
//   pc           PC of the instruction presented this cycle
//   instr        instruction word presented this cycle
//   instr_valid  pc/instr are a retired instruction this cycle
//   restart      single-cycle pulse, honoured only in DONE
//   core_reset   active-high reset to the core
//   running      high while in RUN
//   done         high while in DONE
//   status       00 none, 01 pass (halt), 10 timeout, 11 hang
//   cycle_count  RUN cycles elapsed in the current run (saturating)
//   instr_count  valid instructions retired in the current run (saturating)
//   last_pc      PC of the most recent valid instruction
module sim_run_controller #(
  parameter int          XLEN         = 32,
  parameter int          CNT_W        = 32,
  parameter int          RESET_CYCLES = 2,
  parameter int          MAX_CYCLES   = 100,
  parameter logic [31:0] HALT_INSTR   = 32'h0000000c,
  parameter int          HANG_LIMIT   = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [XLEN-1:0]  pc,
  input  logic [31:0]      instr,
  input  logic             instr_valid,
  input  logic             restart,
  output logic             core_reset,
  output logic             running,
  output logic             done,
  output logic [1:0]       status,
  output logic [CNT_W-1:0] cycle_count,
  output logic [CNT_W-1:0] instr_count,
  output logic [XLEN-1:0]  last_pc
);

  localparam int HW = $clog2(RESET_CYCLES + 1);
  localparam int SW = $clog2(HANG_LIMIT + 1);

  localparam logic [HW-1:0]    HOLD_LAST  = HW'(RESET_CYCLES - 1);
  localparam logic [SW-1:0]    SAME_LAST  = SW'(HANG_LIMIT - 1);
  localparam logic [CNT_W-1:0] CYCLE_LAST = CNT_W'(MAX_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  localparam logic [1:0] ST_NONE    = 2'b00;
  localparam logic [1:0] ST_PASS    = 2'b01;
  localparam logic [1:0] ST_TIMEOUT = 2'b10;
  localparam logic [1:0] ST_HANG    = 2'b11;

  typedef enum logic [1:0] {
    HOLD = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_reg,  state_next;
  logic [HW-1:0]    hold_reg,   hold_next;
  logic [SW-1:0]    same_reg,   same_next;
  logic             seen_reg,   seen_next;
  logic [1:0]       status_reg, status_next;
  logic [CNT_W-1:0] cycle_reg,  cycle_next;
  logic [CNT_W-1:0] instr_reg,  instr_next;
  logic [XLEN-1:0]  lpc_reg,    lpc_next;

  logic is_halt, is_hang, is_tout;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg  <= HOLD;
      hold_reg   <= '0;
      same_reg   <= '0;
      seen_reg   <= 1'b0;
      status_reg <= ST_NONE;
      cycle_reg  <= '0;
      instr_reg  <= '0;
      lpc_reg    <= '0;
    end else begin
      state_reg  <= state_next;
      hold_reg   <= hold_next;
      same_reg   <= same_next;
      seen_reg   <= seen_next;
      status_reg <= status_next;
      cycle_reg  <= cycle_next;
      instr_reg  <= instr_next;
      lpc_reg    <= lpc_next;
    end
  end

  always_comb begin
    state_next  = state_reg;
    hold_next   = hold_reg;
    same_next   = same_reg;
    seen_next   = seen_reg;
    status_next = status_reg;
    cycle_next  = cycle_reg;
    instr_next  = instr_reg;
    lpc_next    = lpc_reg;

    // End conditions look at the pre-edge counters, so the edge that ends
    // the run still counts the final cycle and instruction.
    is_halt = instr_valid && (instr == HALT_INSTR);
    is_hang = instr_valid && seen_reg && (pc == lpc_reg) && (same_reg == SAME_LAST);
    is_tout = (cycle_reg == CYCLE_LAST);

    case (state_reg)
      HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = RUN;
          hold_next  = '0;
        end else begin
          hold_next = hold_reg + HW'(1);
        end
      end

      RUN: begin
        cycle_next = (cycle_reg == '1) ? cycle_reg : cycle_reg + CNT_ONE;
        if (instr_valid) begin
          instr_next = (instr_reg == '1) ? instr_reg : instr_reg + CNT_ONE;
          lpc_next   = pc;
          seen_next  = 1'b1;
          // Repeat-PC run length; it only ever reaches HANG_LIMIT on the
          // edge that ends the run, so it cannot overflow.
          if (!seen_reg || (pc != lpc_reg)) same_next = '0;
          else                              same_next = same_reg + SW'(1);
        end
        if (is_halt || is_hang || is_tout) begin
          state_next = DONE;
          if (is_halt)      status_next = ST_PASS;
          else if (is_hang) status_next = ST_HANG;
          else              status_next = ST_TIMEOUT;
        end
      end

      DONE: begin
        if (restart) begin
          state_next  = HOLD;
          hold_next   = '0;
          same_next   = '0;
          seen_next   = 1'b0;
          status_next = ST_NONE;
          cycle_next  = '0;
          instr_next  = '0;
          lpc_next    = '0;
        end
      end

      default: state_next = HOLD;
    endcase
  end

  // Outputs decode straight from registered state: no input-to-output paths.
  assign core_reset  = (state_reg != RUN);
  assign running     = (state_reg == RUN);
  assign done        = (state_reg == DONE);
  assign status      = status_reg;
  assign cycle_count = cycle_reg;
  assign instr_count = instr_reg;
  assign last_pc     = lpc_reg;

endmodule

// File: tb/tb_sim_run_controller.sv
module tb_sim_run_controller;

  logic        clk;
  logic        reset;
  logic [31:0] pc;
  logic [31:0] instr;
  logic        instr_valid;
  logic        restart;
  logic        core_reset;
  logic        running;
  logic        done;
  logic [1:0]  status;
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
  logic [31:0] last_pc;

  int checks;
  int passed;

  sim_run_controller dut (
    .clk         (clk),
    .reset       (reset),
    .pc          (pc),
    .instr       (instr),
    .instr_valid (instr_valid),
    .restart     (restart),
    .core_reset  (core_reset),
    .running     (running),
    .done        (done),
    .status      (status),
    .cycle_count (cycle_count),
    .instr_count (instr_count),
    .last_pc     (last_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Present one cycle of core activity, clock it, and settle past the edge.
  task automatic cyc(input logic v, input logic [31:0] p, input logic [31:0] i);
    instr_valid = v;
    pc          = p;
    instr       = i;
    @(posedge clk);
    #1;
    instr_valid = 1'b0;
  endtask

  // From DONE: restart and wait out the reset hold, landing in RUN.
  task automatic restart_run();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    checks++;
    if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || status !== 2'b00 ||
        cycle_count !== 32'd0 || instr_count !== 32'd0 || last_pc !== 32'd0)
      $display("FAIL reset_values: cr=%b run=%b done=%b st=%b cyc=%0d ins=%0d lpc=%h required 1 0 0 00 0 0 0",
               core_reset, running, done, status, cycle_count, instr_count, last_pc);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (core_reset !== 1'b1 || running !== 1'b0)
      $display("FAIL hold_edge1: cr=%b run=%b required 1 0", core_reset, running);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (core_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 32'd0)
      $display("FAIL enter_run: cr=%b run=%b cyc=%0d required 0 1 0", core_reset, running, cycle_count);
    else passed++;
    $display("test_reset done");
  endtask

  task automatic test_halt();
    cyc(1'b1, 32'h0, 32'h0);
    restart = 1'b1;               // ignored outside DONE
    cyc(1'b1, 32'h4, 32'h0);
    restart = 1'b0;
    checks++;
    if (running !== 1'b1 || cycle_count !== 32'd2)
      $display("FAIL restart_ignored: run=%b cyc=%0d required 1 2", running, cycle_count);
    else passed++;
    cyc(1'b1, 32'h8, 32'h0);
    cyc(1'b0, 32'h8, 32'h0);
    cyc(1'b1, 32'hc, 32'h0000000c);
    checks++;
    if (done !== 1'b1 || running !== 1'b0 || core_reset !== 1'b1 || status !== 2'b01 ||
        instr_count !== 32'd4 || last_pc !== 32'hc || cycle_count !== 32'd5)
      $display("FAIL halt: done=%b run=%b cr=%b st=%b ins=%0d lpc=%h cyc=%0d required 1 0 1 01 4 c 5",
               done, running, core_reset, status, instr_count, last_pc, cycle_count);
    else passed++;
    cyc(1'b1, 32'h50, 32'h0);
    cyc(1'b1, 32'h54, 32'h0);
    checks++;
    if (done !== 1'b1 || status !== 2'b01 || instr_count !== 32'd4 || last_pc !== 32'hc ||
        cycle_count !== 32'd5)
      $display("FAIL done_hold: done=%b st=%b ins=%0d lpc=%h cyc=%0d required 1 01 4 c 5",
               done, status, instr_count, last_pc, cycle_count);
    else passed++;
    $display("test_halt done");
  endtask

  task automatic test_restart();
    restart = 1'b1;
    @(posedge clk);
    #1;
    restart = 1'b0;
    checks++;
    if (done !== 1'b0 || running !== 1'b0 || core_reset !== 1'b1 || status !== 2'b00 ||
        cycle_count !== 32'd0 || instr_count !== 32'd0 || last_pc !== 32'd0)
      $display("FAIL restart_clear: done=%b run=%b cr=%b st=%b cyc=%0d ins=%0d lpc=%h required 0 0 1 00 0 0 0",
               done, running, core_reset, status, cycle_count, instr_count, last_pc);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (core_reset !== 1'b1 || running !== 1'b0)
      $display("FAIL restart_hold: cr=%b run=%b required 1 0", core_reset, running);
    else passed++;
    @(posedge clk);
    #1;
    checks++;
    if (core_reset !== 1'b0 || running !== 1'b1 || cycle_count !== 32'd0)
      $display("FAIL restart_run: cr=%b run=%b cyc=%0d required 0 1 0", core_reset, running, cycle_count);
    else passed++;
    $display("test_restart done");
  endtask

  task automatic test_timeout();
    for (int i = 0; i < 99; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 32'h0);
    checks++;
    if (running !== 1'b1 || done !== 1'b0 || cycle_count !== 32'd99)
      $display("FAIL timeout_early: run=%b done=%b cyc=%0d required 1 0 99", running, done, cycle_count);
    else passed++;
    cyc(1'b1, 32'h28c, 32'h0);
    checks++;
    if (done !== 1'b1 || status !== 2'b10 || cycle_count !== 32'd100 || instr_count !== 32'd100 ||
        last_pc !== 32'h28c)
      $display("FAIL timeout: done=%b st=%b cyc=%0d ins=%0d lpc=%h required 1 10 100 100 28c",
               done, status, cycle_count, instr_count, last_pc);
    else passed++;
    $display("test_timeout done");
  endtask

  task automatic test_hang();
    restart_run();
    for (int i = 0; i < 4; i++) cyc(1'b1, 32'h20, 32'h0);
    cyc(1'b1, 32'h24, 32'h0);          // breaks the run of 0x20
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h20, 32'h0);
    checks++;
    if (running !== 1'b1 || done !== 1'b0)
      $display("FAIL hang_early: run=%b done=%b required 1 0", running, done);
    else passed++;
    cyc(1'b1, 32'h20, 32'h0);          // 9th consecutive 0x20
    checks++;
    if (done !== 1'b1 || status !== 2'b11 || cycle_count !== 32'd14 || instr_count !== 32'd14 ||
        last_pc !== 32'h20)
      $display("FAIL hang: done=%b st=%b cyc=%0d ins=%0d lpc=%h required 1 11 14 14 20",
               done, status, cycle_count, instr_count, last_pc);
    else passed++;
    $display("test_hang done");
  endtask

  task automatic test_priority();
    restart_run();
    for (int i = 0; i < 91; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 32'h0);
    for (int i = 0; i < 8; i++) cyc(1'b1, 32'h20, 32'h0);
    checks++;
    if (running !== 1'b1 || cycle_count !== 32'd99)
      $display("FAIL priority_early: run=%b cyc=%0d required 1 99", running, cycle_count);
    else passed++;
    // Cycle 100: timeout, 9th repeated PC and halt instruction all at once.
    cyc(1'b1, 32'h20, 32'h0000000c);
    checks++;
    if (done !== 1'b1 || status !== 2'b01 || cycle_count !== 32'd100 || instr_count !== 32'd100)
      $display("FAIL priority: done=%b st=%b cyc=%0d ins=%0d required 1 01 100 100",
               done, status, cycle_count, instr_count);
    else passed++;
    $display("test_priority done");
  endtask

  task automatic test_async_reset();
    restart_run();
    cyc(1'b1, 32'h0, 32'h0);
    cyc(1'b1, 32'h4, 32'h0);
    cyc(1'b1, 32'h8, 32'h0);
    checks++;
    if (running !== 1'b1 || cycle_count !== 32'd3 || last_pc !== 32'h8)
      $display("FAIL async_pre: run=%b cyc=%0d lpc=%h required 1 3 8", running, cycle_count, last_pc);
    else passed++;
    #1;                                // mid high phase, away from any edge
    reset = 1'b0;
    #1;
    checks++;
    if (core_reset !== 1'b1 || running !== 1'b0 || done !== 1'b0 || status !== 2'b00 ||
        cycle_count !== 32'd0 || instr_count !== 32'd0 || last_pc !== 32'd0)
      $display("FAIL async_reset: cr=%b run=%b done=%b st=%b cyc=%0d ins=%0d lpc=%h required 1 0 0 00 0 0 0",
               core_reset, running, done, status, cycle_count, instr_count, last_pc);
    else passed++;
    @(posedge clk);
    #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (running !== 1'b1 || core_reset !== 1'b0 || cycle_count !== 32'd0)
      $display("FAIL async_rerun: run=%b cr=%b cyc=%0d required 1 0 0", running, core_reset, cycle_count);
    else passed++;
    $display("test_async_reset done");
  endtask

  initial begin
    checks      = 0;
    passed      = 0;
    reset       = 1'b0;
    pc          = '0;
    instr       = '0;
    instr_valid = 1'b0;
    restart     = 1'b0;
    test_reset();
    test_halt();
    test_restart();
    test_timeout();
    test_hang();
    test_priority();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/sim_run_controller.md
Name: sim_run_controller

Overview:
Synthesizable run-control and supervision block placed between the top-level bench clock/reset and the `mips` core.
- Sequences the core's reset.
- Counts run cycles and retired instructions.
- Ends a run on a halt instruction, a hang (PC stuck), or a cycle budget, and reports which one.
- Generalises the fixed "reset for one period, stop after a fixed time" bench flow into a parametrised, restartable controller.

Parameters:
- XLEN, 32, width of pc and last_pc.
- CNT_W, 32, width of cycle_count and instr_count.
- RESET_CYCLES, 2, number of clk cycles core_reset is held high at the start of each run; minimum 1.
- MAX_CYCLES, 100, run-cycle budget before timeout; minimum 1.
- HALT_INSTR, 32'h0000000c, instruction word that ends a run successfully.
- HANG_LIMIT, 8, number of consecutive repeated PCs that declares a hang; minimum 1.

Ports:
- clk, input, 1, system clock; all state changes on the rising edge.
- reset, input, 1, asynchronous, active-low; 0 = in reset.
- pc, input, XLEN, PC of the instruction presented this cycle.
- instr, input, 32, instruction word presented this cycle.
- instr_valid, input, 1, pc/instr are a retired instruction this cycle.
- restart, input, 1, single-cycle pulse; honoured only in DONE.
- core_reset, output, 1, active-high reset to the core.
- running, output, 1, high in RUN.
- done, output, 1, high in DONE.
- status, output, 2, 00 none, 01 pass (halt), 10 timeout, 11 hang.
- cycle_count, output, CNT_W, RUN cycles elapsed in the current run.
- instr_count, output, CNT_W, valid instructions retired in the current run.
- last_pc, output, XLEN, PC of the most recent valid instruction.

Behaviour:
- Reset values (reset=0, asynchronous): state=HOLD, core_reset=1, running=0, done=0, status=00, cycle_count=0, instr_count=0, last_pc=0, hold counter=0, same counter=0, pc_seen=0.
- States: HOLD, RUN, DONE. Outputs are registered (no combinational paths from inputs).
- HOLD:
  - core_reset=1; hold counter increments each cycle.
  - After RESET_CYCLES cycles in HOLD, move to RUN. core_reset falls on the same edge that raises running.
  - instr_valid is ignored.
- RUN, each cycle:
  - cycle_count +1.
  - If instr_valid: instr_count +1, last_pc <= pc, pc_seen <= 1.
  - Same counter: set to 0 if pc != last_pc or pc_seen=0; otherwise +1.
- End conditions, evaluated in RUN each cycle:
  - Halt: instr_valid && instr==HALT_INSTR -> status 01.
  - Hang: instr_valid && pc_seen && pc==last_pc && same counter==HANG_LIMIT-1 -> status 11.
  - Timeout: cycle_count==MAX_CYCLES-1 (this is the MAX_CYCLES-th run cycle) -> status 10.
  - Priority when several hold together: halt > hang > timeout.
  - On any end condition, move to DONE on the same edge. The counters still update on that edge, so the halting instruction is counted and cycle_count = cycles spent in RUN.
- DONE:
  - done=1, running=0, core_reset=1 (freezes the core).
  - status, counters and last_pc hold their values; instr_valid is ignored.
  - restart=1: move to HOLD, clear counters, last_pc, pc_seen, same counter and status; done falls.
  - restart outside DONE is ignored.
- Counters saturate at all-ones; they never wrap.
- Asynchronous reset mid-run returns to HOLD with all reset values immediately, no clock edge required.

Test Plan:
- RESET_CYCLES=2: deassert reset -> core_reset=1 for exactly 2 rising edges, then running=1 and core_reset=0 on the same edge; cycle_count=0 at entry to RUN.
- Feed valid PCs 0x0, 0x4, 0x8, then instr=0x0000000c at PC 0xc on run cycle 5 -> done=1, status=01, instr_count=4, last_pc=0xc, cycle_count=5, core_reset=1.
- Feed distinct PCs with no halt, MAX_CYCLES=100 -> done after exactly 100 RUN cycles, status=10, cycle_count=100.
- HANG_LIMIT=8, instr_valid every cycle with pc=0x20 -> hang declared on the 9th consecutive 0x20, status=11. A different PC injected at the 5th occurrence restarts the count.
- Halt instruction arriving on the same cycle as the timeout cycle and the hang threshold -> status=01.
- In DONE, pulse restart -> HOLD, counters=0, status=00, core_reset held for RESET_CYCLES. Pulse reset low mid-RUN -> all outputs return to reset values immediately, with no clock edge.
